// File: rtl/rot_cmd_seq.sv
// Command sequencer driving an external registered barrel rotator.
// Define ROT_CMD_SEQ_CHK_EN to add the result checker behind the sticky err flag.
module rot_cmd_seq #(
    parameter  int DATA_W = 8,
    parameter  int REP_W  = 4,
    localparam int SEL_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [SEL_W-1:0]  cmd_amt,
    input  logic [REP_W-1:0]  cmd_reps,
    output logic              brl_load,
    output logic [SEL_W-1:0]  brl_sel,
    output logic [DATA_W-1:0] brl_data,
    input  logic [DATA_W-1:0] brl_q,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  amt_q, amt_d;
    logic [REP_W-1:0]  reps_q, reps_d;
    logic [REP_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        reps_d  = reps_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    amt_d   = cmd_amt;
                    reps_d  = cmd_reps;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // LOAD already performs the first rotate step
                if (reps_q <= REP_W'(1)) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d   = reps_q - REP_W'(1);
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (cnt_q == REP_W'(1)) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q - REP_W'(1);
                end
            end
            S_CAPT: begin
                res_d   = brl_q;
                state_d = S_RES;
            end
            S_RES: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            reps_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            reps_q  <= reps_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        brl_sel = '0;
        if (state_q == S_LOAD) begin
            brl_sel = (reps_q == '0) ? '0 : amt_q;
        end else if (state_q == S_STEP) begin
            brl_sel = amt_q;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q != S_IDLE);
    assign brl_load  = (state_q == S_LOAD);
    assign brl_data  = data_q;
    assign res_valid = (state_q == S_RES);
    assign res_data  = res_q;

`ifdef ROT_CMD_SEQ_CHK_EN
    logic [SEL_W-1:0]  chk_sh;
    logic [DATA_W-1:0] chk_exp;
    logic              err_q, err_d;

    // Total shift is amt*reps reduced mod DATA_W by the SEL_W-bit sum
    always_comb begin
        chk_sh = '0;
        for (int i = 0; i < (1 << REP_W); i++) begin
            if (i < int'(reps_q)) begin
                chk_sh = chk_sh + amt_q;
            end
        end
        chk_exp = '0;
        for (int i = 0; i < DATA_W; i++) begin
            chk_exp[i] = data_q[(i + int'(chk_sh)) % DATA_W];
        end
        err_d = err_q;
        if ((state_q == S_CAPT) && (brl_q != chk_exp)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rot_cmd_seq.sv
// Bench for rot_cmd_seq with a behavioural registered rotator attached.
// Vector table, back-pressure, abort and random commands vs a reference model.
module tb_rot_cmd_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic [3:0] cmd_reps;
    logic       brl_load;
    logic [2:0] brl_sel;
    logic [7:0] brl_data;
    logic [7:0] brl_q;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rot_q;
    logic       force_zero = 1'b0;

    always #5 clk = ~clk;

    rot_cmd_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_reps(cmd_reps),
        .brl_load(brl_load), .brl_sel(brl_sel), .brl_data(brl_data),
        .brl_q(brl_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err)
    );

    function automatic int rotr(input int x, input int s);
        int k;
        k = s % 8;
        return ((x >> k) | (x << (8 - k))) & 255;
    endfunction

    // External rotator: Load picks brl_data, otherwise feeds back its own q
    always @(posedge clk) begin
        if (reset) rot_q <= 8'h00;
        else if (brl_load) rot_q <= 8'(rotr(int'(brl_data), int'(brl_sel)));
        else rot_q <= 8'(rotr(int'(rot_q), int'(brl_sel)));
    end
    assign brl_q = force_zero ? 8'h00 : rot_q;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int d, input int a, input int r, input int hold,
                           input bit check_res);
        int lat;
        int exp_lat;
        int exp_res;
        int w;
        logic [7:0] held;
        exp_res = (r == 0 || a == 0) ? d : rotr(d, a * r);
        exp_lat = ((r > 1) ? r : 1) + 2;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = 8'(d);
        cmd_amt   = 3'(a);
        cmd_reps  = 4'(r);
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        cmd_amt   = 3'($urandom);
        cmd_reps  = 4'($urandom);
        chk("load_flag", int'(brl_load), 1);
        chk("load_sel", int'(brl_sel), (r == 0) ? 0 : a);
        chk("load_data", int'(brl_data), d);
        cmd_valid = 1'($urandom);
        lat = 1;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        cmd_valid = 1'b0;
        chk("latency", lat, exp_lat);
        if (!res_valid) return;
        if (check_res) chk("res_data", int'(res_data), exp_res);
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_stable", int'(res_data), int'(held));
            chk("bp_valid", int'(res_valid), 1);
            chk("bp_ready", int'(cmd_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ready_after_hs", int'(cmd_ready), 1);
        chk("busy_after_hs", int'(busy), 0);
    endtask

    typedef struct {
        int d;
        int a;
        int r;
        int hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cmd_amt   = 3'd0;
        cmd_reps  = 4'd0;
        res_ready = 1'b0;

        vecs.push_back('{d: 8'h81, a: 1, r: 1, hold: 0});
        vecs.push_back('{d: 8'h01, a: 3, r: 3, hold: 0});
        vecs.push_back('{d: 8'hA5, a: 5, r: 0, hold: 0});
        vecs.push_back('{d: 8'hF0, a: 4, r: 2, hold: 1});
        vecs.push_back('{d: 8'h01, a: 1, r: 15, hold: 0});
        vecs.push_back('{d: 8'h3C, a: 0, r: 5, hold: 0});
        vecs.push_back('{d: 8'h12, a: 7, r: 1, hold: 0});
        vecs.push_back('{d: 8'h5A, a: 3, r: 4, hold: 5});

        tick();
        tick();
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_brl_load", int'(brl_load), 0);
        chk("rst_brl_sel", int'(brl_sel), 0);
        chk("rst_brl_data", int'(brl_data), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].d, vecs[i].a, vecs[i].r, vecs[i].hold, 1'b1);
            chk("err_clean", int'(err), 0);
        end

        // Abort a long command in STEP and start over
        run_cmd(8'h01, 1, 15, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h01;
        cmd_amt   = 3'd1;
        cmd_reps  = 4'd15;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_in_step_busy", int'(busy), 1);
        chk("abort_in_step_sel", int'(brl_sel), 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_data", int'(res_data), 0);
        chk("abort_brl_load", int'(brl_load), 0);
        chk("abort_brl_sel", int'(brl_sel), 0);
        chk("abort_brl_data", int'(brl_data), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 0);
        reset = 1'b0;
        #1;
        chk("abort_rel_ready", int'(cmd_ready), 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (res_valid || busy) seen++;
            end
            chk("abort_no_result", seen, 0);
        end
        run_cmd(8'h3C, 2, 1, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            run_cmd(int'($urandom_range(255)), int'($urandom_range(7)),
                    int'($urandom_range(15)), int'($urandom_range(3)), 1'b1);
        end
        chk("err_after_random", int'(err), 0);

`ifdef ROT_CMD_SEQ_CHK_EN
        force_zero = 1'b1;
        run_cmd(8'h81, 1, 1, 0, 1'b0);
        force_zero = 1'b0;
        chk("chk_err_set", int'(err), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("chk_err_held", int'(err), 1);
        run_cmd(8'h81, 1, 1, 0, 1'b1);
        chk("chk_err_sticky", int'(err), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("chk_err_cleared", int'(err), 0);
`else
        force_zero = 1'b1;
        run_cmd(8'h81, 1, 1, 0, 1'b0);
        force_zero = 1'b0;
        chk("no_chk_err_tied", int'(err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
